// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM states and default operand width.
package mult_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/nbit_addsub.sv
// N-bit adder/subtractor: sum = x + y, or x - y when sub is set (two's complement).
module nbit_addsub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Subtraction as x + ~y + 1.
  assign {cout, sum} = {1'b0, x} + {1'b0, y ^ {N{sub}}} + (N + 1)'(sub);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, fixed latency.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef MULT_SIGNED_EN
  localparam bit SignedMode = 1'b1;
`else
  localparam bit SignedMode = 1'b0;
`endif

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 last_bit;
  logic [WIDTH:0]       add_x, add_y, add_sum;
  logic                 add_sub;
  logic                 unused_cout;
  logic [2*WIDTH-1:0]   acc_next;

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // Upper half and multiplicand are extended by one bit so no carry is lost.
  assign add_x   = {SignedMode & acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
  assign add_y   = mplier_q[0] ? {SignedMode & mcand_q[WIDTH-1], mcand_q} : '0;
  // Signed: the multiplier MSB carries negative weight.
  assign add_sub = SignedMode & last_bit;

  nbit_addsub #(
    .N (WIDTH + 1)
  ) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  // Shift right one: the full (WIDTH+1)-bit sum lands in the top bits.
  assign acc_next = {add_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          product_d = acc_next;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL provide port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL provide port a, input, WIDTH bits: multiplicand, sampled on an accepted start.
REQ-006 The block SHALL provide port b, input, WIDTH bits: multiplier, sampled on an accepted start.
REQ-007 The block SHALL provide port busy, output, 1 bit: high while a multiplication is in progress.
REQ-008 The block SHALL provide port done, output, 1 bit: one-cycle pulse marking a valid product.
REQ-009 The block SHALL provide port product, output, 2*WIDTH bits: result of the last completed multiplication.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 In IDLE or DONE, start=1 SHALL be accepted: capture a and b, clear the accumulator and the bit counter, and enter CALC on the next edge.
REQ-012 In CALC, each cycle SHALL examine one multiplier bit, LSB first, add the multiplicand to the accumulator's upper half when that bit is 1, then shift the accumulator right one bit with the adder carry shifted in.
REQ-013 CALC SHALL last exactly WIDTH cycles, then transition to DONE.
REQ-014 Latency SHALL be fixed, independent of operand values: done is asserted WIDTH+1 cycles after the edge on which start was accepted.
REQ-015 DONE SHALL last one cycle, with done=1, and SHALL return to IDLE unless start=1, in which case the next operation is accepted (back-to-back).
REQ-016 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.
REQ-017 start while in CALC SHALL be ignored, with no effect on operands, counter or result.
REQ-018 product SHALL update only on entry to DONE and SHALL hold its value through IDLE and any subsequent CALC until the next DONE.
REQ-019 The adder SHALL be WIDTH+1 bits wide so that no carry is lost; the maximum operands (2^WIDTH-1)^2 SHALL produce the exact result.
REQ-020 Operands changing after acceptance SHALL NOT affect the result in progress.

Reset
REQ-021 While rst_n=0 at a rising edge, the FSM SHALL enter IDLE and busy, done, product, accumulator and counter SHALL be cleared to 0.
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse; start SHALL be accepted on the first edge after rst_n returns to 1.

Configuration
REQ-023 Macro MULT_SIGNED_EN, when defined, SHALL make a, b and product two's complement.
REQ-024 With MULT_SIGNED_EN defined, the add shall sign-extend the multiplicand, and the final CALC cycle (multiplier MSB) SHALL subtract instead of add; latency is unchanged.
REQ-025 Without MULT_SIGNED_EN, all operands and product SHALL be unsigned.

Structure
REQ-026 A shared package mult_pkg SHALL hold the FSM state enumeration (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-027 The WIDTH+1-bit add/subtract datapath SHALL be a sub-module named nbit_addsub (inputs x, y, sub; outputs sum, cout); all other logic is in the top module.

Verification (WIDTH=4)
REQ-028 Unsigned: a=3, b=5, start pulse -> busy for 4 cycles, done on cycle 5, product=8'h0F.
REQ-029 Max: a=15, b=15 -> product=8'hE1 (225); zero: a=0, b=9 -> product=8'h00 with the same latency.
REQ-030 start held high during CALC with a=7, b=7 -> ignored; product is that of the first operation; a second start in the DONE cycle is accepted back-to-back with no IDLE gap.
REQ-031 rst_n=0 for one cycle at CALC cycle 2 -> no done pulse, product=0, busy=0; a new operation afterwards gives the correct result.
REQ-032 MULT_SIGNED_EN defined: a=4'hD (-3), b=4'h5 -> product=8'hF1 (-15); a=4'h8, b=4'h8 -> product=8'h40 (64).
